// File: rtl/adc_acq_controller.sv
// adc_acq_controller: nSYNC sequencing, frame watchdog and
// per-channel streaming of captured ADC frames.
module adc_acq_controller #(
  parameter int N_CH       = 4,
  parameter int FRAME_BITS = 64,
  parameter int SYNC_LEN   = 8,
  parameter int TIMEOUT    = 1024,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       MCLK,
  input  logic                       nRST,
  input  logic                       ENABLE,
  input  logic                       RESYNC,
  input  logic                       CLR_ERR,
  input  logic                       FRAME_VALID,
  input  logic [N_CH*FRAME_BITS-1:0] FRAME_DATA,
  output logic                       nSYNC,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [FRAME_BITS-1:0]      OUT_DATA,
  output logic [CH_W-1:0]            OUT_CH,
  output logic                       OUT_LAST,
  output logic [15:0]                FRAME_CNT,
  output logic                       OVERRUN,
  output logic                       TIMEOUT_ERR,
  output logic                       BUSY
);

  localparam int SC_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam int WD_W = $clog2(TIMEOUT);

  localparam logic [SC_W-1:0] SYNC_LAST = SC_W'(SYNC_LEN - 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0] CH_LAST   = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_WAIT,
    S_SEND
  } state_e;

  state_e                  state_q, state_d;
  logic [SC_W-1:0]         sync_cnt_q, sync_cnt_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic [FRAME_BITS-1:0]   frame_q [N_CH];
  logic [FRAME_BITS-1:0]   frame_d [N_CH];
  logic                    nsync_q, nsync_d;
  logic                    valid_q, valid_d;
  logic [FRAME_BITS-1:0]   data_q, data_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [CH_W-1:0]         ch_nxt;
  logic                    last_q, last_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    ovr_q, ovr_d;
  logic                    terr_q, terr_d;
  logic                    busy_q, busy_d;
  logic                    load;
  logic                    ovr_set;
  logic                    terr_set;

  assign nSYNC       = nsync_q;
  assign OUT_VALID   = valid_q;
  assign OUT_DATA    = data_q;
  assign OUT_CH      = ch_q;
  assign OUT_LAST    = last_q;
  assign FRAME_CNT   = cnt_q;
  assign OVERRUN     = ovr_q;
  assign TIMEOUT_ERR = terr_q;
  assign BUSY        = busy_q;

  // Next-state, stream outputs and error set conditions
  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    wd_d       = wd_q;
    frame_d    = frame_q;
    valid_d    = valid_q;
    data_d     = data_q;
    ch_d       = ch_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    ovr_set    = 1'b0;
    terr_set   = 1'b0;
    ch_nxt     = ch_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (ENABLE) begin
          state_d    = S_SYNC;
          sync_cnt_d = '0;
        end
      end
      S_SYNC: begin
        if (sync_cnt_q == SYNC_LAST) begin
          state_d = S_WAIT;
          wd_d    = '0;
        end else begin
          sync_cnt_d = sync_cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (RESYNC) begin
          state_d    = S_SYNC;
          sync_cnt_d = '0;
        end else if (FRAME_VALID) begin
          load = 1'b1;
        end else if (wd_q == WD_LAST) begin
          terr_set   = 1'b1;
          state_d    = S_SYNC;
          sync_cnt_d = '0;
        end else if (!ENABLE) begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (RESYNC) begin
          state_d    = S_SYNC;
          sync_cnt_d = '0;
          valid_d    = 1'b0;
          last_d     = 1'b0;
        end else begin
          // A frame landing exactly on the last handshake is a clean
          // back-to-back hand-over, anything earlier is dropped.
          if (FRAME_VALID && !(OUT_READY && last_q)) begin
            ovr_set = 1'b1;
          end
          if (OUT_READY) begin
            if (last_q) begin
              cnt_d = cnt_q + 1'b1;
              if (FRAME_VALID) begin
                load = 1'b1;
              end else begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                wd_d    = '0;
                state_d = ENABLE ? S_WAIT : S_IDLE;
              end
            end else begin
              ch_d   = ch_nxt;
              data_d = frame_q[ch_nxt];
              last_d = (ch_nxt == CH_LAST);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      for (int k = 0; k < N_CH; k++) begin
        frame_d[k] = FRAME_DATA[FRAME_BITS*k +: FRAME_BITS];
      end
      state_d = S_SEND;
      valid_d = 1'b1;
      ch_d    = '0;
      data_d  = FRAME_DATA[FRAME_BITS-1:0];
      last_d  = (N_CH == 1);
    end
  end

  // Registered nSYNC/BUSY and sticky flags (set beats clear)
  always_comb begin
    nsync_d = (state_d != S_SYNC);
    busy_d  = (state_d != S_IDLE);
    ovr_d   = ovr_set | (ovr_q & ~CLR_ERR);
    terr_d  = terr_set | (terr_q & ~CLR_ERR);
  end

  // State and output registers
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      sync_cnt_q <= '0;
      wd_q       <= '0;
      for (int k = 0; k < N_CH; k++) begin
        frame_q[k] <= '0;
      end
      nsync_q    <= 1'b1;
      valid_q    <= 1'b0;
      data_q     <= '0;
      ch_q       <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      ovr_q      <= 1'b0;
      terr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      wd_q       <= wd_d;
      frame_q    <= frame_d;
      nsync_q    <= nsync_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      ch_q       <= ch_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      ovr_q      <= ovr_d;
      terr_q     <= terr_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_adc_acq_controller.sv
// tb_adc_acq_controller: scenario tasks with randomized frames
// checked against a queue-based model of the delivered stream.
module tb_adc_acq_controller;

  logic         MCLK;
  logic         nRST;
  logic         ENABLE;
  logic         RESYNC;
  logic         CLR_ERR;
  logic         FRAME_VALID;
  logic [255:0] FRAME_DATA;
  logic         nSYNC;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [63:0]  OUT_DATA;
  logic [1:0]   OUT_CH;
  logic         OUT_LAST;
  logic [15:0]  FRAME_CNT;
  logic         OVERRUN;
  logic         TIMEOUT_ERR;
  logic         BUSY;

  adc_acq_controller dut (
    .MCLK        (MCLK),
    .nRST        (nRST),
    .ENABLE      (ENABLE),
    .RESYNC      (RESYNC),
    .CLR_ERR     (CLR_ERR),
    .FRAME_VALID (FRAME_VALID),
    .FRAME_DATA  (FRAME_DATA),
    .nSYNC       (nSYNC),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_DATA    (OUT_DATA),
    .OUT_CH      (OUT_CH),
    .OUT_LAST    (OUT_LAST),
    .FRAME_CNT   (FRAME_CNT),
    .OVERRUN     (OVERRUN),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .BUSY        (BUSY)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;
  logic [63:0] words [4];
  logic [63:0] exp_q [$];
  int          exp_ch [$];

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic rand_words();
    for (int k = 0; k < 4; k++) begin
      words[k] = {$urandom, $urandom};
    end
  endtask

  // Present one frame in WAIT; expect channel 0 one cycle later.
  task automatic start_frame();
    FRAME_DATA  = {words[3], words[2], words[1], words[0]};
    FRAME_VALID = 1'b1;
    OUT_READY   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(words[k]);
      exp_ch.push_back(k);
    end
    tick();
    FRAME_VALID = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_CH !== 2'd0) begin
      errors++;
      $display("FAIL start_latency valid=%b ch=%0d want 1/0",
               OUT_VALID, OUT_CH);
    end
  endtask

  // Accept n words; mode 0 ready=1, 1 pattern 1,0,0,1, 2 random.
  task automatic collect(input int mode, input int n);
    int hs  = 0;
    int cyc = 0;
    bit rdy;
    bit hs_now;
    while (hs < n && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      checks++;
      if (OUT_VALID !== 1'b1) begin
        errors++;
        $display("FAIL stream_valid got=%b want 1", OUT_VALID);
      end else begin
        checks++;
        if (OUT_DATA !== exp_q[0] || OUT_CH !== 2'(exp_ch[0]) ||
            OUT_LAST !== (exp_ch[0] == 3)) begin
          errors++;
          $display("FAIL stream_word got=%h/%0d/%b want %h/%0d/%b",
                   OUT_DATA, OUT_CH, OUT_LAST,
                   exp_q[0], exp_ch[0], exp_ch[0] == 3);
        end
      end
      OUT_READY = rdy;
      hs_now    = (OUT_VALID === 1'b1) && rdy;
      if (hs_now) begin
        if (exp_ch[0] == 3) exp_cnt++;
        void'(exp_q.pop_front());
        void'(exp_ch.pop_front());
        hs++;
      end
      tick();
      cyc++;
      if (hs_now) begin
        checks++;
        if (FRAME_CNT !== exp_cnt) begin
          errors++;
          $display("FAIL frame_cnt got=%0d want %0d",
                   FRAME_CNT, exp_cnt);
        end
      end
    end
    checks++;
    if (hs < n) begin
      errors++;
      $display("FAIL collect_budget got=%0d want %0d words", hs, n);
    end
    if (exp_q.size() == 0) begin
      checks++;
      if (OUT_VALID !== 1'b0 || OUT_LAST !== 1'b0) begin
        errors++;
        $display("FAIL frame_end valid=%b last=%b want 0/0",
                 OUT_VALID, OUT_LAST);
      end
    end
  endtask

  // Count a nSYNC low pulse that has just started.
  task automatic count_sync(input string tag);
    int n = 0;
    while (nSYNC === 1'b0 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n != 8 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL %s_pulse got=%0d busy=%b want 8 busy=1",
               tag, n, BUSY);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; ENABLE = 1'b0; RESYNC = 1'b0; CLR_ERR = 1'b0;
    FRAME_VALID = 1'b0; FRAME_DATA = '0; OUT_READY = 1'b0;
    repeat (3) tick();
    checks++;
    if ({nSYNC, OUT_VALID, OUT_LAST, OVERRUN, TIMEOUT_ERR, BUSY}
        !== 6'b100000 || OUT_DATA !== 64'd0 || OUT_CH !== 2'd0 ||
        FRAME_CNT !== 16'd0) begin
      errors++;
      $display("FAIL reset_state flags=%b data=%h ch=%0d cnt=%0d",
               {nSYNC, OUT_VALID, OUT_LAST, OVERRUN, TIMEOUT_ERR,
                BUSY}, OUT_DATA, OUT_CH, FRAME_CNT);
    end
    nRST = 1'b1;
    repeat (2) tick();
    checks++;
    if (BUSY !== 1'b0 || nSYNC !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold busy=%b nsync=%b want 0/1",
               BUSY, nSYNC);
    end
  endtask

  task automatic test_sync();
    ENABLE = 1'b1;
    tick();
    checks++;
    if (nSYNC !== 1'b0 || BUSY !== 1'b1 || TIMEOUT_ERR !== 1'b0) begin
      errors++;
      $display("FAIL sync_start nsync=%b busy=%b terr=%b want 0/1/0",
               nSYNC, BUSY, TIMEOUT_ERR);
    end
    count_sync("enable");
  endtask

  task automatic test_stream();
    words[0] = 64'h1111_1111_1111_1111;
    words[1] = 64'h2222_2222_2222_2222;
    words[2] = 64'h3333_3333_3333_3333;
    words[3] = 64'h4444_4444_4444_4444;
    start_frame();
    collect(0, 4);
  endtask

  task automatic test_overrun();
    rand_words();
    start_frame();
    FRAME_DATA  = ~FRAME_DATA;
    FRAME_VALID = 1'b1;
    tick();
    FRAME_VALID = 1'b0;
    checks++;
    if (OVERRUN !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got=%b want 1", OVERRUN);
    end
    collect(1, 4);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    checks++;
    if (OVERRUN !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got=%b want 0", OVERRUN);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a3;
    rand_words();
    a3 = words[3];
    start_frame();
    collect(0, 3);
    checks++;
    if (OUT_LAST !== 1'b1 || OUT_DATA !== a3) begin
      errors++;
      $display("FAIL b2b_last last=%b data=%h want 1/%h",
               OUT_LAST, OUT_DATA, a3);
    end
    void'(exp_q.pop_front());
    void'(exp_ch.pop_front());
    exp_cnt++;
    rand_words();
    FRAME_DATA  = {words[3], words[2], words[1], words[0]};
    FRAME_VALID = 1'b1;
    OUT_READY   = 1'b1;
    tick();
    FRAME_VALID = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(words[k]);
      exp_ch.push_back(k);
    end
    checks++;
    if (OVERRUN !== 1'b0 || FRAME_CNT !== exp_cnt) begin
      errors++;
      $display("FAIL b2b_handover ovr=%b cnt=%0d want 0/%0d",
               OVERRUN, FRAME_CNT, exp_cnt);
    end
    collect(2, 4);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 15)) tick();
      rand_words();
      start_frame();
      collect(2, 4);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    rand_words();
    start_frame();
    collect(0, 4);
    while (TIMEOUT_ERR !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n != 1024) begin
      errors++;
      $display("FAIL watchdog_delay got=%0d want 1024", n);
    end
    count_sync("watchdog");
    checks++;
    if (TIMEOUT_ERR !== 1'b1 || nSYNC !== 1'b1) begin
      errors++;
      $display("FAIL watchdog_after terr=%b nsync=%b want 1/1",
               TIMEOUT_ERR, nSYNC);
    end
    rand_words();
    start_frame();
    collect(0, 4);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    checks++;
    if (TIMEOUT_ERR !== 1'b0) begin
      errors++;
      $display("FAIL terr_clear got=%b want 0", TIMEOUT_ERR);
    end
  endtask

  task automatic test_resync();
    rand_words();
    start_frame();
    collect(0, 2);
    RESYNC    = 1'b1;
    OUT_READY = 1'b1;
    tick();
    RESYNC = 1'b0;
    exp_q.delete();
    exp_ch.delete();
    checks++;
    if (OUT_VALID !== 1'b0 || OUT_LAST !== 1'b0 ||
        FRAME_CNT !== exp_cnt || nSYNC !== 1'b0) begin
      errors++;
      $display("FAIL resync_abort v=%b l=%b cnt=%0d ns=%b want 0/0/%0d/0",
               OUT_VALID, OUT_LAST, FRAME_CNT, nSYNC, exp_cnt);
    end
    count_sync("resync");
  endtask

  task automatic test_disable();
    rand_words();
    start_frame();
    ENABLE = 1'b0;
    collect(2, 4);
    checks++;
    if (BUSY !== 1'b0 || nSYNC !== 1'b1) begin
      errors++;
      $display("FAIL disable_idle busy=%b nsync=%b want 0/1",
               BUSY, nSYNC);
    end
  endtask

  task automatic test_reset_mid();
    rand_words();
    start_frame();
    exp_q.delete();
    exp_ch.delete();
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if ({nSYNC, OUT_VALID, OUT_LAST, OVERRUN, TIMEOUT_ERR, BUSY}
        !== 6'b100000 || OUT_DATA !== 64'd0 || OUT_CH !== 2'd0 ||
        FRAME_CNT !== 16'd0) begin
      errors++;
      $display("FAIL async_reset flags=%b data=%h ch=%0d cnt=%0d",
               {nSYNC, OUT_VALID, OUT_LAST, OVERRUN, TIMEOUT_ERR,
                BUSY}, OUT_DATA, OUT_CH, FRAME_CNT);
    end
    ENABLE = 1'b0;
    exp_cnt = '0;
    tick();
    nRST = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_sync();
    test_stream();
    test_overrun();
    test_back_to_back();
    test_random();
    test_timeout();
    test_resync();
    collect(0, 0);
    test_disable();
    test_sync();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
